// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_pkg
// Brief   : Op encodings, FSM states and data-memory geometry for the
//           memory-access stage and the data memory beside it.
// Revision: 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int DM_DW    = 16;
    localparam int DM_AW    = 16;
    localparam int DM_DEPTH = 16;
    localparam int DM_RW    = 3;

    typedef enum logic [1:0] {
        OP_PASS  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_LOAD_WAIT = 2'd2
    } state_e;

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_stage
// Brief   : Pipeline memory-access stage: issues loads/stores to a
//           registered-read data memory and returns a registered result.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DW    = DM_DW,
    parameter int AW    = DM_AW,
    parameter int DEPTH = DM_DEPTH,
    parameter int RW    = DM_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    input  logic [DW-1:0] in_alu,
    input  logic [RW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_rd,
    output logic          out_wen,
    output logic          out_fault,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata
);

    localparam logic [AW-1:0] C_DEPTH = AW'(DEPTH);

    state_e        r_state;
    state_e        w_next_state;
    op_e           r_req_op;
    logic [AW-1:0] r_req_addr;
    logic [DW-1:0] r_req_wdata;
    logic [DW-1:0] r_req_alu;
    logic [RW-1:0] r_req_rd;
    logic          r_req_fault;

    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic [RW-1:0] r_out_rd;
    logic          r_out_wen;
    logic          r_out_fault;

    logic          w_accept;
    logic          w_in_fault;
    logic          w_fill;
    logic [DW-1:0] w_fill_data;
    logic          w_fill_wen;
    logic          w_fill_fault;

    assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready) && !rst;
    assign w_accept = in_valid && in_ready;

    // Full-width unsigned compare: out-of-range addresses never alias a word.
    assign w_in_fault = (is_mem_op(in_op) && (in_addr >= C_DEPTH)) || (in_op == OP_RSVD);

    always_comb begin
        w_next_state = r_state;
        w_fill       = 1'b0;
        w_fill_data  = '0;
        w_fill_wen   = 1'b0;
        w_fill_fault = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if ((r_req_op == OP_LOAD) && !r_req_fault) begin
                    w_next_state = ST_LOAD_WAIT;
                end else begin
                    w_next_state = ST_IDLE;
                    w_fill       = 1'b1;
                    w_fill_fault = r_req_fault;
                    if (!r_req_fault && (r_req_op == OP_PASS)) begin
                        w_fill_data = r_req_alu;
                        w_fill_wen  = 1'b1;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                // Memory registered the read at the end of ISSUE.
                w_next_state = ST_IDLE;
                w_fill       = 1'b1;
                w_fill_data  = dm_rdata;
                w_fill_wen   = 1'b1;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_op    <= OP_PASS;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_alu   <= '0;
            r_req_rd    <= '0;
            r_req_fault <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_rd    <= '0;
            r_out_wen   <= 1'b0;
            r_out_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_req_op    <= op_e'(in_op);
                r_req_addr  <= in_addr;
                r_req_wdata <= in_wdata;
                r_req_alu   <= in_alu;
                r_req_rd    <= in_rd;
                r_req_fault <= w_in_fault;
            end
            if (w_fill) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_fill_data;
                r_out_rd    <= r_req_rd;
                r_out_wen   <= w_fill_wen;
                r_out_fault <= w_fill_fault;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Write strobe gated by rst so a store caught in ISSUE by reset is dropped.
    assign dm_we    = (r_state == ST_ISSUE) && (r_req_op == OP_STORE) && !r_req_fault && !rst;
    assign dm_addr  = r_req_addr;
    assign dm_wdata = r_req_wdata;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_rd    = r_out_rd;
    assign out_wen   = r_out_wen;
    assign out_fault = r_out_fault;

endmodule
`default_nettype wire
